mem_port_arbiter: RTL and testbench

Two-requester controller that shares the single-port, byte-wide test memory model between an instruction-fetch port (port 0) and a load/store port (port 1). It accepts full-word requests and arbitrates between ports round-robin. Each accepted word is sequenced as BYTES consecutive byte accesses on the memory's cs/we/addr/data bus, with read bytes assembled little-endian. It sits between the core's fetch/LSU and the memory model in the testbench top.

---
 rtl/mem_port_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mem_port_arbiter                                              |
// | Function : Round-robin arbiter between a fetch port (0) and a load/store |
// |            port (1). Each accepted word is carried out as BYTES byte     |
// |            accesses on a single-port byte-wide memory, little-endian.    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module mem_port_arbiter #(
   parameter int  ADDR_WIDTH = 32,
   parameter int  DATA_WIDTH = 8,
   parameter int  BYTES      = 4,
   localparam int W          = BYTES * DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   // port 0 : instruction fetch
   input  logic                  req0_valid,
   output logic                  req0_ready,
   input  logic [ADDR_WIDTH-1:0] req0_addr,
   input  logic                  req0_we,
   input  logic [W-1:0]          req0_wdata,
   input  logic [BYTES-1:0]      req0_be,
   output logic                  resp0_valid,
   output logic [W-1:0]          resp0_rdata,
   // port 1 : load/store
   input  logic                  req1_valid,
   output logic                  req1_ready,
   input  logic [ADDR_WIDTH-1:0] req1_addr,
   input  logic                  req1_we,
   input  logic [W-1:0]          req1_wdata,
   input  logic [BYTES-1:0]      req1_be,
   output logic                  resp1_valid,
   output logic [W-1:0]          resp1_rdata,
   // byte-wide memory bus
   output logic                  mem_cs,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   input  logic                  mem_vld
);

   localparam int            KW     = (BYTES > 1) ? $clog2(BYTES) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(BYTES - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   state_t                  state;
   state_t                  state_nx;

   logic                    last_grant;
   logic                    port;
   logic [ADDR_WIDTH-1:0]   lat_addr;
   logic                    lat_we;
   logic [W-1:0]            lat_wdata;
   logic [BYTES-1:0]        lat_be;
   logic [KW-1:0]           k;
   logic [W-1:0]            acc;

   logic                    grant_any;
   logic                    grant_port;
   logic                    accept;
   logic                    be_k;
   logic [DATA_WIDTH-1:0]   wbyte_k;

   // Round-robin choice: a lone requester always wins, a tie goes to the port that lost last time.
   always_comb begin
      grant_any  = req0_valid | req1_valid;
      grant_port = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
   end

   // Select the byte enable and write byte belonging to the current step.
   always_comb begin
      be_k    = lat_be[0];
      wbyte_k = lat_wdata[DATA_WIDTH-1:0];
      for (int i = 0; i < BYTES; i++) begin
         if (k == KW'(i)) begin
            be_k    = lat_be[i];
            wbyte_k = lat_wdata[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // Address and write byte come straight from the latched request and step counter,
   // so they naturally hold their last value whenever the FSM is not stepping.
   assign mem_addr  = lat_addr + ADDR_WIDTH'(k);
   assign mem_wdata = wbyte_k;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state and output decode; handshake outputs are masked while reset is held.
   always_comb begin
      state_nx    = state;
      accept      = 1'b0;
      req0_ready  = 1'b0;
      req1_ready  = 1'b0;
      resp0_valid = 1'b0;
      resp1_valid = 1'b0;
      resp0_rdata = '0;
      resp1_rdata = '0;
      mem_cs      = 1'b0;
      mem_we      = 1'b0;
      case (state)
         IDLE: begin
            if (grant_any) begin
               accept     = 1'b1;
               req0_ready = rst_n & ~grant_port;
               req1_ready = rst_n & grant_port;
               state_nx   = ACCESS;
            end
         end
         ACCESS: begin
            // a masked write byte still spends its cycle, just with the chip deselected
            mem_cs = ~lat_we | be_k;
            mem_we = lat_we & be_k;
            if (mem_vld && (k == K_LAST)) begin
               state_nx = RESP;
            end
         end
         RESP: begin
            resp0_valid = ~port;
            resp1_valid = port;
            resp0_rdata = port ? '0 : acc;
            resp1_rdata = port ? acc : '0;
            state_nx    = IDLE;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   // Request latch, byte step counter and little-endian read assembly.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant <= 1'b1;
         port       <= 1'b0;
         lat_addr   <= '0;
         lat_we     <= 1'b0;
         lat_wdata  <= '0;
         lat_be     <= '0;
         k          <= '0;
         acc        <= '0;
      end else if (accept) begin
         last_grant <= grant_port;
         port       <= grant_port;
         lat_addr   <= grant_port ? req1_addr  : req0_addr;
         lat_we     <= grant_port ? req1_we    : req0_we;
         lat_wdata  <= grant_port ? req1_wdata : req0_wdata;
         lat_be     <= grant_port ? req1_be    : req0_be;
         k          <= '0;
         acc        <= '0;
      end else if ((state == ACCESS) && mem_vld) begin
         if (!lat_we) begin
            for (int i = 0; i < BYTES; i++) begin
               if (k == KW'(i)) begin
                  acc[i*DATA_WIDTH +: DATA_WIDTH] <= mem_rdata;
               end
            end
         end
         // k parks on the last byte so mem_addr keeps pointing at the final byte afterwards
         if (k != K_LAST) begin
            k <= k + 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_mem_port_arbiter                                           |
// | Function : Self-checking bench for mem_port_arbiter with a 16-byte       |
// |            memory model and a word-level reference model.                |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_mem_port_arbiter;

   localparam int AW = 4;
   localparam int DW = 8;
   localparam int NB = 4;
   localparam int W  = NB * DW;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          req0_valid, req0_ready, req0_we, resp0_valid;
   logic [AW-1:0] req0_addr;
   logic [W-1:0]  req0_wdata, resp0_rdata;
   logic [NB-1:0] req0_be;
   logic          req1_valid, req1_ready, req1_we, resp1_valid;
   logic [AW-1:0] req1_addr;
   logic [W-1:0]  req1_wdata, resp1_rdata;
   logic [NB-1:0] req1_be;
   logic          mem_cs, mem_we, mem_vld;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata;

   // memory model plus a preload port used only while the DUT is in reset
   logic [7:0]    mem [16];
   logic [7:0]    ref_mem [16];
   logic          poke_en;
   logic [3:0]    poke_a;
   logic [7:0]    poke_d;

   int total = 0;
   int bad   = 0;

   // results recorded by run_txn
   int            grant_wait, resp_lat, resp_port, obs_n, exp_n;
   logic [W-1:0]  obs_rdata;
   bit            other_bad, resp_after, resp_cs_bad;
   logic [13:0]   obs_key [64];
   logic [13:0]   exp_key [64];

   mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTES(NB)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr),
      .req0_we(req0_we), .req0_wdata(req0_wdata), .req0_be(req0_be),
      .resp0_valid(resp0_valid), .resp0_rdata(resp0_rdata),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr),
      .req1_we(req1_we), .req1_wdata(req1_wdata), .req1_be(req1_be),
      .resp1_valid(resp1_valid), .resp1_rdata(resp1_rdata),
      .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_vld(mem_vld)
   );

   always #5 clk = ~clk;

   assign mem_rdata = mem[mem_addr];

   always @(posedge clk) begin
      if (poke_en) mem[poke_a] <= poke_d;
      else if (mem_cs && mem_we && mem_vld) mem[mem_addr] <= mem_wdata;
   end

   // ---------------- reference model ----------------
   function automatic logic [31:0] ref_read(input logic [3:0] a);
      logic [31:0] r;
      for (int b = 0; b < NB; b++) r[8*b +: 8] = ref_mem[(int'(a) + b) % 16];
      return r;
   endfunction

   task automatic ref_write(input logic [3:0] a, input logic [31:0] wd, input logic [3:0] be);
      for (int b = 0; b < NB; b++)
         if (be[b]) ref_mem[(int'(a) + b) % 16] = wd[8*b +: 8];
   endtask

   // Expected bus trace, one entry per cycle between grant and response: {cs, we, addr, wbyte}
   task automatic build_exp(input logic [3:0] a, input logic we, input logic [31:0] wd,
                            input logic [3:0] be, input int stall_byte, input int nstall);
      int   reps;
      logic en, wr;
      exp_n = 0;
      for (int b = 0; b < NB; b++) begin
         reps = (b == stall_byte) ? nstall + 1 : 1;
         en   = we ? be[b] : 1'b1;
         wr   = we & be[b];
         for (int r = 0; r < reps; r++) begin
            exp_key[exp_n] = {en, wr, 4'((int'(a) + b) % 16), wr ? wd[8*b +: 8] : 8'h00};
            exp_n++;
         end
      end
   endtask

   // ---------------- transaction driver (records, does not judge) ----------------
   task automatic run_txn(input int p, input logic [3:0] a, input logic we, input logic [31:0] wd,
                          input logic [3:0] be, input int stall_byte, input int nstall, input bit nosync);
      int done_steps;
      int stalls_left;
      done_steps  = 0;
      stalls_left = nstall;
      grant_wait = -1; resp_lat = -1; resp_port = -1; obs_n = 0; obs_rdata = '0;
      other_bad = 0; resp_after = 0; resp_cs_bad = 0;
      if (!nosync) @(negedge clk);
      mem_vld = 1'b1;
      if (p == 0) begin
         req0_valid = 1; req0_addr = a; req0_we = we; req0_wdata = wd; req0_be = be;
      end else begin
         req1_valid = 1; req1_addr = a; req1_we = we; req1_wdata = wd; req1_be = be;
      end
      for (int c = 0; c < 30; c++) begin
         #1;
         if ((p == 0) ? req1_ready : req0_ready) other_bad = 1;
         if ((p == 0) ? req0_ready : req1_ready) begin
            grant_wait = c;
            break;
         end
         @(negedge clk);
      end
      if (grant_wait < 0) begin
         req0_valid = 0; req1_valid = 0;
         return;
      end
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (i == 1) begin
            if (p == 0) req0_valid = 0; else req1_valid = 0;
         end
         if (done_steps == stall_byte && stalls_left > 0) begin
            mem_vld = 0;
            stalls_left--;
         end else begin
            mem_vld = 1;
         end
         #1;
         if ((p == 0) ? (req1_ready | resp1_valid | (resp1_rdata != 0))
                      : (req0_ready | resp0_valid | (resp0_rdata != 0))) other_bad = 1;
         if (resp0_valid || resp1_valid) begin
            resp_lat    = i;
            resp_port   = resp1_valid ? 1 : 0;
            obs_rdata   = resp1_valid ? resp1_rdata : resp0_rdata;
            resp_cs_bad = mem_cs | mem_we;
            break;
         end
         if (obs_n < 64) begin
            obs_key[obs_n] = {mem_cs, mem_we, mem_addr, mem_we ? mem_wdata : 8'h00};
            obs_n++;
         end
         if (mem_vld) done_steps++;
      end
      mem_vld = 1;
      if (resp_lat > 0) begin
         @(negedge clk);
         #1;
         resp_after = resp0_valid | resp1_valid;
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      req0_valid = 1; req0_addr = 4'd0; req0_we = 0; req0_wdata = '0; req0_be = '0;
      req1_valid = 1; req1_addr = 4'd4; req1_we = 0; req1_wdata = '0; req1_be = '0;
      @(negedge clk);
      #1;
      total++;
      if ({req0_ready, req1_ready, resp0_valid, resp1_valid} !== 4'b0) begin
         bad++; $display("FAIL reset_handshake: got %b, expected 0000", {req0_ready, req1_ready, resp0_valid, resp1_valid});
      end
      total++;
      if ({resp0_rdata, resp1_rdata} !== 64'h0) begin
         bad++; $display("FAIL reset_rdata: got %h %h, expected 0", resp0_rdata, resp1_rdata);
      end
      total++;
      if ({mem_cs, mem_we, mem_addr, mem_wdata} !== 14'h0) begin
         bad++; $display("FAIL reset_membus: got cs=%b we=%b addr=%h wd=%h, expected all 0", mem_cs, mem_we, mem_addr, mem_wdata);
      end
      @(negedge clk);
      rst_n = 1;
   endtask

   // Both ports valid straight out of reset; port 0 comes back for a second word.
   task automatic test_tie();
      int          grants[$];
      int          rports[$];
      logic [31:0] rdat[$];
      int          exp_g[3];
      logic [31:0] exp_d[3];
      bit          dual, r0, r1;
      int          g0;
      dual = 0; g0 = 0;
      exp_g = '{0, 1, 0};
      exp_d = '{ref_read(4'd0), ref_read(4'd4), ref_read(4'd2)};
      mem_vld = 1;
      for (int c = 0; c < 80 && rports.size() < 3; c++) begin
         #1;
         r0 = req0_ready; r1 = req1_ready;
         if ((r0 && r1) || (resp0_valid && resp1_valid)) dual = 1;
         if (r0) grants.push_back(0); else if (r1) grants.push_back(1);
         if (resp0_valid) begin rports.push_back(0); rdat.push_back(resp0_rdata); end
         else if (resp1_valid) begin rports.push_back(1); rdat.push_back(resp1_rdata); end
         @(negedge clk);
         if (r0) begin
            g0++;
            if (g0 == 1) req0_addr = 4'd2; else req0_valid = 0;
         end
         if (r1) req1_valid = 0;
      end
      req0_valid = 0; req1_valid = 0;
      total++;
      if (dual) begin bad++; $display("FAIL tie_exclusive: got two ports active together, expected one"); end
      for (int j = 0; j < 3; j++) begin
         total++;
         if (j >= grants.size() || grants[j] != exp_g[j]) begin
            bad++; $display("FAIL tie_grant[%0d]: got %0d, expected port %0d", j, (j < grants.size()) ? grants[j] : -1, exp_g[j]);
         end
         total++;
         if (j >= rports.size() || rports[j] != exp_g[j] || rdat[j] !== exp_d[j]) begin
            bad++; $display("FAIL tie_resp[%0d]: got port %0d data %h, expected port %0d data %h", j,
                            (j < rports.size()) ? rports[j] : -1, (j < rdat.size()) ? rdat[j] : 32'hx, exp_g[j], exp_d[j]);
         end
      end
   endtask

   task automatic test_read();
      build_exp(4'd0, 1'b0, '0, '0, -1, 0);
      run_txn(0, 4'd0, 1'b0, '0, '0, -1, 0, 0);
      total++;
      if (grant_wait != 0) begin bad++; $display("FAIL read_grant: got wait %0d, expected 0", grant_wait); end
      total++;
      if (obs_n != exp_n) begin bad++; $display("FAIL read_len: got %0d bus cycles, expected %0d", obs_n, exp_n); end
      for (int j = 0; j < exp_n && j < obs_n; j++) begin
         total++;
         if (obs_key[j] !== exp_key[j]) begin bad++; $display("FAIL read_bus[%0d]: got %h, expected %h", j, obs_key[j], exp_key[j]); end
      end
      total++;
      if (resp_lat != NB + 1 || resp_port != 0) begin
         bad++; $display("FAIL read_resp: got latency %0d port %0d, expected %0d port 0", resp_lat, resp_port, NB + 1);
      end
      total++;
      if (obs_rdata !== 32'h76543210 || obs_rdata !== ref_read(4'd0)) begin
         bad++; $display("FAIL read_data: got %h, expected 76543210", obs_rdata);
      end
      total++;
      if (other_bad || resp_after || resp_cs_bad) begin
         bad++; $display("FAIL read_side: got other=%b resp_after=%b cs_in_resp=%b, expected 000", other_bad, resp_after, resp_cs_bad);
      end
   endtask

   task automatic test_write_be();
      build_exp(4'd8, 1'b1, 32'hAABBCCDD, 4'b0101, -1, 0);
      run_txn(1, 4'd8, 1'b1, 32'hAABBCCDD, 4'b0101, -1, 0, 0);
      ref_write(4'd8, 32'hAABBCCDD, 4'b0101);
      total++;
      if (obs_n != exp_n) begin bad++; $display("FAIL wr_len: got %0d bus cycles, expected %0d", obs_n, exp_n); end
      for (int j = 0; j < exp_n && j < obs_n; j++) begin
         total++;
         if (obs_key[j] !== exp_key[j]) begin bad++; $display("FAIL wr_bus[%0d]: got %h, expected %h", j, obs_key[j], exp_key[j]); end
      end
      total++;
      if (resp_lat != NB + 1 || resp_port != 1 || obs_rdata !== 32'h0) begin
         bad++; $display("FAIL wr_resp: got latency %0d port %0d data %h, expected %0d port 1 data 0", resp_lat, resp_port, obs_rdata, NB + 1);
      end
      run_txn(0, 4'd8, 1'b0, '0, '0, -1, 0, 0);
      total++;
      if (obs_rdata !== 32'h00BB00DD || obs_rdata !== ref_read(4'd8)) begin
         bad++; $display("FAIL wr_readback: got %h, expected 00bb00dd", obs_rdata);
      end
   endtask

   task automatic test_wait_states();
      build_exp(4'd4, 1'b0, '0, '0, 2, 3);
      run_txn(1, 4'd4, 1'b0, '0, '0, 2, 3, 0);
      total++;
      if (obs_n != exp_n) begin bad++; $display("FAIL wait_len: got %0d bus cycles, expected %0d", obs_n, exp_n); end
      for (int j = 0; j < exp_n && j < obs_n; j++) begin
         total++;
         if (obs_key[j] !== exp_key[j]) begin bad++; $display("FAIL wait_bus[%0d]: got %h, expected %h", j, obs_key[j], exp_key[j]); end
      end
      total++;
      if (resp_lat != NB + 1 + 3 || obs_rdata !== ref_read(4'd4)) begin
         bad++; $display("FAIL wait_resp: got latency %0d data %h, expected %0d data %h", resp_lat, obs_rdata, NB + 4, ref_read(4'd4));
      end
   endtask

   task automatic test_wrap();
      build_exp(4'd14, 1'b0, '0, '0, -1, 0);
      run_txn(0, 4'd14, 1'b0, '0, '0, -1, 0, 0);
      total++;
      if (obs_n != exp_n) begin bad++; $display("FAIL wrap_len: got %0d bus cycles, expected %0d", obs_n, exp_n); end
      for (int j = 0; j < exp_n && j < obs_n; j++) begin
         total++;
         if (obs_key[j] !== exp_key[j]) begin bad++; $display("FAIL wrap_bus[%0d]: got %h, expected %h", j, obs_key[j], exp_key[j]); end
      end
      total++;
      if (obs_rdata !== 32'h3210F2E1 || obs_rdata !== ref_read(4'd14)) begin
         bad++; $display("FAIL wrap_data: got %h, expected 3210f2e1", obs_rdata);
      end
   endtask

   task automatic test_reset_mid();
      int got;
      bit seen;
      got = -1; seen = 0;
      @(negedge clk);
      mem_vld = 1;
      req1_valid = 1; req1_addr = 4'd4; req1_we = 0; req1_wdata = '0; req1_be = '0;
      for (int c = 0; c < 10; c++) begin
         #1;
         if (req1_ready) begin got = c; break; end
         @(negedge clk);
      end
      total++;
      if (got != 0) begin bad++; $display("FAIL midrst_grant: got wait %0d, expected 0", got); end
      @(negedge clk);
      @(negedge clk);
      #1;
      total++;
      if (mem_addr !== 4'd5 || mem_cs !== 1'b1) begin
         bad++; $display("FAIL midrst_byte1: got addr %h cs %b, expected addr 5 cs 1", mem_addr, mem_cs);
      end
      @(negedge clk);
      #2;
      rst_n = 0;
      #1;
      total++;
      if ({req0_ready, req1_ready, resp0_valid, resp1_valid, mem_cs, mem_we, mem_addr, mem_wdata} !== 18'h0 ||
          {resp0_rdata, resp1_rdata} !== 64'h0) begin
         bad++; $display("FAIL midrst_outputs: got rdy=%b%b resp=%b%b cs=%b we=%b addr=%h wd=%h, expected all 0",
                         req0_ready, req1_ready, resp0_valid, resp1_valid, mem_cs, mem_we, mem_addr, mem_wdata);
      end
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         #1;
         if (resp0_valid || resp1_valid || mem_cs || req1_ready) seen = 1;
      end
      total++;
      if (seen) begin bad++; $display("FAIL midrst_quiet: got activity during reset, expected none"); end
      @(negedge clk);
      rst_n = 1;
      build_exp(4'd4, 1'b0, '0, '0, -1, 0);
      run_txn(1, 4'd4, 1'b0, '0, '0, -1, 0, 1);
      total++;
      if (grant_wait != 0 || resp_lat != NB + 1 || resp_port != 1 || obs_rdata !== ref_read(4'd4)) begin
         bad++; $display("FAIL midrst_regrant: got wait %0d latency %0d port %0d data %h, expected 0 %0d 1 %h",
                         grant_wait, resp_lat, resp_port, obs_rdata, NB + 1, ref_read(4'd4));
      end
   endtask

   task automatic test_random();
      int          p, sb, ns, mism, exp_lat;
      logic [3:0]  a, be;
      logic        we;
      logic [31:0] wd, exp_d;
      for (int n = 0; n < 24; n++) begin
         p  = int'($urandom % 2);
         a  = 4'($urandom % 16);
         we = 1'($urandom % 2);
         wd = $urandom;
         be = 4'($urandom % 16);
         sb = int'($urandom % 6) - 2;
         ns = int'($urandom % 3);
         exp_lat = NB + 1 + ((sb >= 0) ? ns : 0);
         exp_d   = we ? 32'h0 : ref_read(a);
         build_exp(a, we, wd, be, sb, ns);
         run_txn(p, a, we, wd, be, sb, ns, 0);
         if (we) ref_write(a, wd, be);
         mism = (obs_n != exp_n) ? 1 : 0;
         for (int j = 0; j < exp_n && j < obs_n; j++) if (obs_key[j] !== exp_key[j]) mism++;
         total++;
         if (mism != 0) begin bad++; $display("FAIL rnd_bus[%0d]: got %0d differing cycles, expected 0", n, mism); end
         total++;
         if (grant_wait != 0 || resp_lat != exp_lat || resp_port != p || obs_rdata !== exp_d) begin
            bad++; $display("FAIL rnd_resp[%0d]: got wait %0d latency %0d port %0d data %h, expected 0 %0d %0d %h",
                            n, grant_wait, resp_lat, resp_port, obs_rdata, exp_lat, p, exp_d);
         end
         total++;
         if (other_bad || resp_after || resp_cs_bad) begin
            bad++; $display("FAIL rnd_side[%0d]: got other=%b resp_after=%b cs_in_resp=%b, expected 000", n, other_bad, resp_after, resp_cs_bad);
         end
      end
      mism = 0;
      for (int i = 0; i < 16; i++) if (mem[i] !== ref_mem[i]) mism++;
      total++;
      if (mism != 0) begin bad++; $display("FAIL rnd_memory: got %0d differing bytes, expected 0", mism); end
   endtask

   // Global time limit so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 0; mem_vld = 1; poke_en = 0; poke_a = '0; poke_d = '0;
      req0_valid = 0; req0_addr = '0; req0_we = 0; req0_wdata = '0; req0_be = '0;
      req1_valid = 0; req1_addr = '0; req1_we = 0; req1_wdata = '0; req1_be = '0;
      for (int i = 0; i < 16; i++) ref_mem[i] = 8'h00;
      ref_mem[0] = 8'h10; ref_mem[1] = 8'h32; ref_mem[2] = 8'h54; ref_mem[3] = 8'h76;
      ref_mem[4] = 8'h44; ref_mem[5] = 8'h55; ref_mem[6] = 8'h66; ref_mem[7] = 8'h77;
      ref_mem[14] = 8'hE1; ref_mem[15] = 8'hF2;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         poke_en = 1; poke_a = 4'(i); poke_d = ref_mem[i];
      end
      @(negedge clk);
      poke_en = 0;

      test_reset();
      test_tie();
      test_read();
      test_write_be();
      test_wait_states();
      test_wrap();
      test_reset_mid();
      test_random();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
